blink_meter: RTL

Receive side of the board's LED-blink signalling. Samples an asynchronous square wave, typically a blinker output looped back or brought in from another board, on CLOCK_50. Measures every half-period in clock cycles and reports it. Declares lock after a run of in-tolerance half-periods, and flags a stuck input by timeout. It sits at the pin boundary, between an input pad and status/debug logic such as LEDs or a 7-segment display.

---
 rtl/blink_pkg.sv | 14 +
 rtl/blink_meter_sync_edge.sv | 33 +++
 rtl/blink_meter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/blink_pkg.sv
// Shared constants for the LED-blink signalling pair (blinker and meter).
// Holds the meter FSM state encoding and the board clock defaults.
package blink_pkg;

  localparam int CLK_HZ    = 50000000;
  localparam int DEFAULT_W = 26;

  typedef logic [1:0] state_t;

  localparam state_t IDLE    = 2'd0;
  localparam state_t MEASURE = 2'd1;
  localparam state_t LOCKED  = 2'd2;

endpackage

// File: rtl/blink_meter_sync_edge.sv
// Brings the asynchronous blink input into the CLOCK_50 domain and flags
// every transition, rising or falling, as a single-cycle strobe.
module sync_edge
  import blink_pkg::*;
(
  input  logic CLOCK_50,
  input  logic reset,
  input  logic d_async,
  output logic q_sync,
  output logic sig_edge
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  // Two metastability flops followed by a history flop for edge detection.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= d_async;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign q_sync   = s2_q;
  assign sig_edge = s2_q ^ s3_q;

endmodule

// File: rtl/blink_meter.sv
// Receive side of the LED-blink link: measures each half-period of the
// synchronized input, declares lock after a run of in-tolerance intervals
// and reports loss of input when no edge arrives within the timeout.
module blink_meter
  import blink_pkg::*;
#(
  parameter int W           = DEFAULT_W,
  parameter int HALF_PERIOD = CLK_HZ,
  parameter int TOL         = 50000,
  parameter int LOCK_COUNT  = 4,
  parameter int TIMEOUT     = 60000000
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  input  logic         sig_in,
  output logic [W-1:0] period_out,
  output logic         period_valid,
  output logic         locked,
  output logic         timeout
);

  localparam int WP     = W + 1;
  localparam int GW     = $clog2(LOCK_COUNT + 1);
  localparam int GWP    = GW + 1;
  localparam int LO_INT = (HALF_PERIOD > TOL) ? (HALF_PERIOD - TOL) : 0;

  // Tolerance window and timeout expressed one bit wider than the counter
  // so that cnt+1 can be compared without wrapping.
  localparam logic [W:0]  TOL_LO    = WP'(LO_INT);
  localparam logic [W:0]  TOL_HI    = WP'(HALF_PERIOD + TOL);
  localparam logic [W:0]  TIMEOUT_N = WP'(TIMEOUT);
  localparam logic [GW:0] LOCK_N    = GWP'(LOCK_COUNT);

  logic          edgeDet;
  logic          unusedSyncLevel;

  state_t        state_q, state_d;
  logic [W-1:0]  cnt_q, cnt_d;
  logic [GW-1:0] good_q, good_d;
  logic [W-1:0]  period_q, period_d;
  logic          valid_q, valid_d;
  logic          timeout_q, timeout_d;
  logic          locked_q;

  logic [W:0]    intervalN;
  logic [GW:0]   goodNext;
  logic          inTol;
  logic          atTimeout;

  sync_edge u_sync (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .d_async  (sig_in),
    .q_sync   (unusedSyncLevel),
    .sig_edge (edgeDet)
  );

  assign intervalN = {1'b0, cnt_q} + {{W{1'b0}}, 1'b1};
  assign goodNext  = {1'b0, good_q} + {{GW{1'b0}}, 1'b1};
  assign inTol     = (intervalN >= TOL_LO) && (intervalN <= TOL_HI);
  assign atTimeout = (intervalN == TIMEOUT_N);

  // Next-state logic: an edge always wins over a coincident timeout.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    good_d    = good_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (edgeDet) begin
          state_d = MEASURE;
          good_d  = '0;
        end
      end
      MEASURE: begin
        if (edgeDet) begin
          cnt_d    = '0;
          period_d = intervalN[W-1:0];
          valid_d  = 1'b1;
          if (inTol) begin
            if (goodNext == LOCK_N) begin
              state_d = LOCKED;
              good_d  = '0;
            end else begin
              good_d = goodNext[GW-1:0];
            end
          end else begin
            good_d = '0;
          end
        end else if (atTimeout) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
          cnt_d     = '0;
          good_d    = '0;
        end else begin
          cnt_d = intervalN[W-1:0];
        end
      end
      LOCKED: begin
        if (edgeDet) begin
          cnt_d    = '0;
          period_d = intervalN[W-1:0];
          valid_d  = 1'b1;
          if (!inTol) begin
            state_d = MEASURE;
            good_d  = '0;
          end
        end else if (atTimeout) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
          cnt_d     = '0;
          good_d    = '0;
        end else begin
          cnt_d = intervalN[W-1:0];
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        good_d  = '0;
      end
    endcase
  end

  // State, counters and registered outputs; reset clears everything at once.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      good_q    <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      good_q    <= good_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      locked_q  <= (state_d == LOCKED);
    end
  end

  assign period_out   = period_q;
  assign period_valid = valid_q;
  assign locked       = locked_q;
  assign timeout      = timeout_q;

endmodule
